and_unit_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise AND unit among

---
 rtl/and_unit_arbiter_pkg.sv | 16 +
 rtl/and_unit_arbiter_and_vec.sv | 17 +
 rtl/and_unit_arbiter.sv | 131 +++++++++++++
 tb/tb_and_unit_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/and_unit_arbiter_pkg.sv
`default_nettype none
// and_unit_arbiter_pkg: state encoding and default sizing shared by the arbiter slice.
// Revision: 1.0
package and_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

endpackage
`default_nettype wire

// File: rtl/and_unit_arbiter_and_vec.sv
`default_nettype none
// and_vec: WIDTH-bit bitwise AND built from replicated 1-bit cells.
// Revision: 1.0
module and_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] c_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign c_o[i] = a_i[i] & b_i[i];
  end

endmodule
`default_nettype wire

// File: rtl/and_unit_arbiter.sv
`default_nettype none
// and_unit_arbiter: round-robin sequencer sharing one WIDTH-bit AND unit among NREQ clients.
// Revision: 1.0
module and_unit_arbiter
  import and_unit_arbiter_pkg::*;
#(
  parameter int    WIDTH = DEF_WIDTH,
  parameter int    NREQ  = DEF_NREQ,
  localparam int   IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  rsp_valid_o,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]      rsp_data_o,
  input  logic                  rsp_ready_i,
  output logic                  busy_o
);

  state_e            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    ptr_d;
  logic [IDW-1:0]    id_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [WIDTH-1:0]  rsp_data_q;

  logic              w_any;
  logic [IDW-1:0]    w_win;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH-1:0]  w_and;

  // First valid requester scanning upward from ptr, wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] win;
    logic           found;
    int             idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    return win;
  endfunction

  assign w_any = |req_valid_i;
  assign w_win = rr_pick(req_valid_i, ptr_q);

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_a = req_a_i[i*WIDTH +: WIDTH];
        w_b = req_b_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (!rst && (state_q == ST_IDLE) && w_any) begin
      req_ready_o[w_win] = 1'b1;
    end
  end

  assign ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

  and_vec #(.WIDTH(WIDTH)) u_and_vec (
    .a_i (a_q),
    .b_i (b_q),
    .c_o (w_and)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_any) begin
            a_q     <= w_a;
            b_q     <= w_b;
            id_q    <= w_win;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= w_and;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_and_unit_arbiter.sv
`default_nettype none
// tb_and_unit_arbiter: directed and randomized checks of the shared-AND round-robin arbiter.
// Revision: 1.0
module tb_and_unit_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready;
  logic           busy;

  int             errors = 0;
  int             checks = 0;
  int             mptr   = 0;
  logic [W-1:0]   a_val [N];
  logic [W-1:0]   b_val [N];

  and_unit_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_ready_i (rsp_ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the first requester at or after the pointer, modulo N, wins.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_val[i];
      req_b[i*W +: W] = b_val[i];
    end
  endtask

  task automatic run_txn(input logic [N-1:0] v, input int stall, input bit scramble);
    int         w;
    logic [W-1:0] ed;
    @(negedge clk);
    req_valid = v;
    drive_ops();
    rsp_ready = 1'b0;
    #1;
    w  = pick(v, mptr);
    ed = a_val[w] & b_val[w];
    chk("grant", req_ready, 32'd1 << w);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_ready", req_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    if (scramble) req_a = '0;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, w);
    chk("rsp_data", rsp_data, ed);
    chk("resp_ready", req_ready, 0);
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, w);
      chk("stall_data", rsp_data, ed);
      chk("stall_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
    mptr = (w + 1) % N;
  endtask

  initial begin
    // Reset with requests asserted: nothing may be granted while rst is high.
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '1;
    req_b     = '1;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin a_val[i] = '0; b_val[i] = '0; end
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", req_ready, 0);
      chk("idle_busy0", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
    end

    // Single operation from requester 2.
    a_val[2] = 8'hF0; b_val[2] = 8'h3C;
    run_txn(4'b0100, 0, 1'b0);

    // All requesters held valid: rotation from the pointer.
    for (int i = 0; i < N; i++) begin
      a_val[i] = W'($urandom); b_val[i] = W'($urandom);
    end
    repeat (5) run_txn(4'b1111, 0, 1'b0);

    // Backpressure in RESP.
    run_txn(4'b1111, 5, 1'b0);

    // Operand change after the accept edge.
    for (int i = 0; i < N; i++) begin a_val[i] = 8'hFF; b_val[i] = 8'h0F; end
    run_txn(4'b1010, 0, 1'b1);

    // Asynchronous reset while in EXEC discards the transaction.
    @(negedge clk);
    req_valid = 4'b0010;
    a_val[1] = 8'h5A; b_val[1] = 8'hFF;
    drive_ops();
    @(posedge clk);
    #3;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_ready", req_ready, 0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst  = 1'b0;
    mptr = 0;
    repeat (4) begin
      @(negedge clk);
      chk("post_arst_rsp_valid", rsp_valid, 0);
      chk("post_arst_busy", busy, 0);
    end
    run_txn(4'b1000, 0, 1'b0);
    mptr = 0;
    rst  = 1'b1;
    #2;
    rst  = 1'b0;
    run_txn(4'b1111, 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        a_val[i] = W'($urandom); b_val[i] = W'($urandom);
      end
      run_txn(N'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
